sync_debounce: RTL

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_debounce.sv | 89 ++++++++
 1 files changed

// File: rtl/sync_debounce.sv
// sync_debounce
//   Per-channel input conditioner: a STAGES-deep synchroniser followed by a
//   debounce filter that accepts a new level only after it has persisted for
//   DEBOUNCE consecutive clock edges. Edge pulses mark accepted transitions.
//
// Parameters
//   WIDTH     : number of independent channels (1..32)
//   STAGES    : synchroniser depth (>= 2)
//   DEBOUNCE  : edges a new level must persist before acceptance (>= 1)
//   RESET_VAL : reset level of every synchroniser stage and stable output
//
// Ports
//   clk        : single clock, all state on its rising edge
//   resetn     : asynchronous active-low reset
//   async_in   : raw asynchronous inputs
//   sync_out   : synchronised, undebounced level (last synchroniser stage)
//   stable_out : debounced level
//   rise       : one-cycle pulse after stable_out goes 0->1
//   fall       : one-cycle pulse after stable_out goes 1->0
module sync_debounce #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned DEBOUNCE  = 16,
    parameter bit          RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [WIDTH-1:0] RST_VEC  = {WIDTH{RESET_VAL}};

    logic [WIDTH-1:0] syncStage [STAGES];
    logic [CNT_W-1:0] debounceCnt [WIDTH];

    // Synchroniser chain; stage 0 samples the raw inputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                syncStage[s] <= RST_VEC;
            end
        end else begin
            syncStage[0] <= async_in;
            for (int unsigned s = 1; s < STAGES; s++) begin
                syncStage[s] <= syncStage[s-1];
            end
        end
    end

    assign sync_out = syncStage[STAGES-1];

    // Debounce filter. The counter tracks how many consecutive edges the
    // synchronised level has disagreed with the accepted level; the edge that
    // finds it at DEBOUNCE-1 with the disagreement still present accepts the
    // new level, so acceptance lands exactly DEBOUNCE edges after the change.
    // Pulses are registered on that same edge so they align with stable_out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable_out <= RST_VEC;
            rise       <= '0;
            fall       <= '0;
            for (int unsigned ch = 0; ch < WIDTH; ch++) begin
                debounceCnt[ch] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            for (int unsigned ch = 0; ch < WIDTH; ch++) begin
                if (sync_out[ch] == stable_out[ch]) begin
                    debounceCnt[ch] <= '0;
                end else if (debounceCnt[ch] == CNT_LAST) begin
                    stable_out[ch]  <= sync_out[ch];
                    rise[ch]        <= sync_out[ch];
                    fall[ch]        <= ~sync_out[ch];
                    debounceCnt[ch] <= '0;
                end else begin
                    debounceCnt[ch] <= debounceCnt[ch] + 1'b1;
                end
            end
        end
    end

endmodule
